// File: rtl/blob_motion_ctrl_if.sv
// Bus between hit detection / video timing and the blob position controller.
// Inputs to the controller: hcount, vcount (raster position), hit strobe, hit_dir.
// Outputs from the controller: x, y (blob top-left), state, frame_tick.
interface blob_motion_ctrl_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hit;
  logic [1:0]  hit_dir;
  logic [10:0] x;
  logic [9:0]  y;
  logic [1:0]  state;
  logic        frame_tick;

  // master: timing generator / hit detector side; slave: the controller
  modport master (
    output hcount, vcount, hit, hit_dir,
    input  x, y, state, frame_tick
  );
  modport slave (
    input  hcount, vcount, hit, hit_dir,
    output x, y, state, frame_tick
  );
endinterface

// File: rtl/blob_motion_ctrl.sv
// Blob position controller: launch on drum hit, bounce off edges for MOVE_FRAMES frames, glide home.
// Latency: x/y/state/frame_tick change only on the frame-event edge (hcount==0, first blanking line).
// Backpressure: none; hits between frames collapse into one pending request, latest direction wins.
// Ports: pixel_clk (only clock), reset_n (async active-low), bus (slave modport):
//   in hcount[10:0], vcount[9:0], hit, hit_dir[1:0] ([1]=left, [0]=up);
//   out x[10:0], y[9:0], state[1:0] (00 idle, 01 move, 10 return), frame_tick.
module blob_motion_ctrl #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int SCREEN_W    = 1024,
  parameter int SCREEN_H    = 768,
  parameter int HOME_X      = 352,
  parameter int HOME_Y      = 264,
  parameter int STEP        = 8,
  parameter int MOVE_FRAMES = 60
) (
  input logic               pixel_clk,
  input logic               reset_n,
  blob_motion_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MOVE   = 2'b01,
    ST_RETURN = 2'b10
  } state_t;

  localparam logic [11:0]        X_MAX    = 12'(SCREEN_W - WIDTH);
  localparam logic [11:0]        Y_MAX    = 12'(SCREEN_H - HEIGHT);
  localparam logic [10:0]        HOME_X11 = 11'(HOME_X);
  localparam logic [9:0]         HOME_Y10 = 10'(HOME_Y);
  localparam logic [11:0]        HOME_X12 = {1'b0, HOME_X11};
  localparam logic [11:0]        HOME_Y12 = {2'b00, HOME_Y10};
  localparam logic [11:0]        STEP12   = 12'(STEP);
  localparam logic signed [12:0] STEP13   = 13'(STEP);
  localparam logic [9:0]         V_FE     = 10'(SCREEN_H);
  localparam logic [7:0]         MOVE_CNT = 8'(MOVE_FRAMES);

  // One bouncing step along an axis. Returns {flip, new_pos}; the signed
  // intermediate lets an overshoot past either edge be clamped, not wrapped.
  function automatic logic [12:0] bounce(input logic [11:0] pos, input logic neg,
                                         input logic [11:0] lim);
    logic signed [11:0] nxt;
    nxt = neg ? ($signed(pos) - $signed(STEP12)) : ($signed(pos) + $signed(STEP12));
    if (nxt < 12'sd0)
      return {1'b1, 12'd0};
    else if (nxt > $signed(lim))
      return {1'b1, lim};
    else
      return {1'b0, nxt};
  endfunction

  // Move toward home by STEP, snapping once the remaining distance is within STEP.
  function automatic logic [11:0] approach(input logic [11:0] pos, input logic [11:0] home);
    logic signed [12:0] d;
    d = $signed({1'b0, home}) - $signed({1'b0, pos});
    if (d > STEP13)
      return pos + STEP12;
    else if (d < -STEP13)
      return pos - STEP12;
    else
      return home;
  endfunction

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [1:0]  dir_q, dir_d;
  logic        pending_q, pending_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tick_q, tick_d;

  logic        fe;
  logic        hit_now;
  logic [1:0]  load_dir;
  logic [12:0] step_x, step_y;
  logic [11:0] home_x, home_y;
  logic        unused_bits;

  assign fe       = (bus.hcount == 11'd0) && (bus.vcount == V_FE);
  assign hit_now  = pending_q | bus.hit;
  // A hit landing on the frame edge itself overrides the pending direction.
  assign load_dir = bus.hit ? bus.hit_dir : dir_q;

  assign step_x = bounce({1'b0, x_q}, dir_q[1], X_MAX);
  assign step_y = bounce({2'b00, y_q}, dir_q[0], Y_MAX);
  assign home_x = approach({1'b0, x_q}, HOME_X12);
  assign home_y = approach({2'b00, y_q}, HOME_Y12);
  // Upper bits are always zero after clamping to the screen.
  assign unused_bits = ^{step_x[11], step_y[11:10]};

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      x_q       <= HOME_X11;
      y_q       <= HOME_Y10;
      dir_q     <= 2'b00;
      pending_q <= 1'b0;
      cnt_q     <= 8'd0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    if (!fe) begin
      if (bus.hit) begin
        pending_d = 1'b1;
        dir_d     = bus.hit_dir;
      end
    end else begin
      tick_d    = 1'b1;
      pending_d = 1'b0;
      if (hit_now) begin
        // Launch or relaunch: reload direction and frame budget, hold position this frame.
        state_d = ST_MOVE;
        dir_d   = load_dir;
        cnt_d   = MOVE_CNT;
      end else begin
        case (state_q)
          ST_MOVE: begin
            x_d   = step_x[10:0];
            y_d   = step_y[9:0];
            dir_d = dir_q ^ {step_x[12], step_y[12]};
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1)
              state_d = ST_RETURN;
          end
          ST_RETURN: begin
            x_d = home_x[10:0];
            y_d = home_y[9:0];
            if ((home_x == HOME_X12) && (home_y == HOME_Y12))
              state_d = ST_IDLE;
          end
          ST_IDLE: ;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.state      = state_q;
  assign bus.frame_tick = tick_q;

endmodule
